stage4_mem: RTL and testbench

STAGE4_MEM -- requirements
Module: stage4_mem

---
 rtl/stage4_mem.sv | 270 +++++++++++++++++++++++++++
 tb/tb_stage4_mem.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4_mem.sv
// Memory-access pipeline stage: retires ALU results directly, issues at most one
// data-memory transaction at a time, and formats load data for write-back.
module stage4_mem (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        valid,
    input  logic        do_load,
    input  logic        do_store,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic [4:0]  rd,
    input  logic [31:0] eval,
    input  logic [31:0] store_data,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall_req,
    output logic        valid_out,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    state_e      state_q, state_d;

    // Memory interface registers
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    // Captured attributes of the in-flight access
    logic        is_load_q, is_load_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] held_q, held_d;

    // Write-back output registers
    logic        valid_out_q, valid_out_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        mis_q, mis_d;

    logic        accept;
    logic        is_mem;
    logic        misalign;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;
    logic [31:0] mem_result;
    logic [4:0]  mem_rd;

    logic        ret_valid;
    logic [31:0] ret_result;
    logic [4:0]  ret_rd;
    logic        ret_mis;

    assign accept = (state_q == StIdle) & valid & ~stall;
    assign is_mem = do_load | do_store;

    always_comb begin
        misalign = 1'b0;
        if (is_mem) begin
            unique case (mem_size)
                SizeByte: misalign = 1'b0;
                SizeHalf: misalign = eval[0];
                SizeWord: misalign = (eval[1:0] != 2'b00);
                default:  misalign = 1'b1;
            endcase
        end
    end

    // Lane steering: narrow stores are replicated so any enabled lane sees the data
    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = 32'h0;
        unique case (mem_size)
            SizeByte: begin
                be_calc    = 4'b0001 << eval[1:0];
                wdata_calc = {4{store_data[7:0]}};
            end
            SizeHalf: begin
                be_calc    = eval[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{store_data[15:0]}};
            end
            SizeWord: begin
                be_calc    = 4'b1111;
                wdata_calc = store_data;
            end
            default: begin
                be_calc    = 4'b0000;
                wdata_calc = 32'h0;
            end
        endcase
    end

    always_comb begin
        load_byte = dmem_rdata[7:0];
        case (lane_q)
            2'd0:    load_byte = dmem_rdata[7:0];
            2'd1:    load_byte = dmem_rdata[15:8];
            2'd2:    load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        load_val = dmem_rdata;
        case (size_q)
            SizeByte: load_val = {{24{~uns_q & load_byte[7]}}, load_byte};
            SizeHalf: load_val = {{16{~uns_q & load_half[15]}}, load_half};
            default:  load_val = dmem_rdata;
        endcase

        mem_result = is_load_q ? load_val : 32'h0;
        mem_rd     = is_load_q ? rd_q : 5'd0;
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        is_load_d   = is_load_q;
        size_d      = size_q;
        lane_d      = lane_q;
        uns_d       = uns_q;
        rd_d        = rd_q;
        held_d      = held_q;
        valid_out_d = valid_out_q;
        result_d    = result_q;
        rd_out_d    = rd_out_q;
        mis_d       = mis_q;

        ret_valid   = 1'b0;
        ret_result  = 32'h0;
        ret_rd      = 5'd0;
        ret_mis     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!is_mem) begin
                        ret_valid  = 1'b1;
                        ret_result = eval;
                        ret_rd     = rd;
                    end else if (misalign) begin
                        ret_valid = 1'b1;
                        ret_mis   = 1'b1;
                    end else begin
                        state_d   = StWait;
                        req_d     = 1'b1;
                        we_d      = do_store;
                        addr_d    = {eval[31:2], 2'b00};
                        wdata_d   = wdata_calc;
                        be_d      = be_calc;
                        is_load_d = do_load;
                        size_d    = mem_size;
                        lane_d    = eval[1:0];
                        uns_d     = load_unsigned;
                        rd_d      = rd;
                    end
                end
            end
            StWait: begin
                if (dmem_ack) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (stall) begin
                        // Read data is only valid with ack, so park the formatted value
                        state_d = StDone;
                        held_d  = mem_result;
                    end else begin
                        state_d    = StIdle;
                        ret_valid  = 1'b1;
                        ret_result = mem_result;
                        ret_rd     = mem_rd;
                    end
                end
            end
            StDone: begin
                if (!stall) begin
                    state_d    = StIdle;
                    ret_valid  = 1'b1;
                    ret_result = held_q;
                    ret_rd     = is_load_q ? rd_q : 5'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!stall) begin
            valid_out_d = ret_valid;
            result_d    = ret_result;
            rd_out_d    = ret_rd;
            mis_d       = ret_mis;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'b0000;
            is_load_q   <= 1'b0;
            size_q      <= 2'd0;
            lane_q      <= 2'd0;
            uns_q       <= 1'b0;
            rd_q        <= 5'd0;
            held_q      <= 32'h0;
            valid_out_q <= 1'b0;
            result_q    <= 32'h0;
            rd_out_q    <= 5'd0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            is_load_q   <= is_load_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            uns_q       <= uns_d;
            rd_q        <= rd_d;
            held_q      <= held_d;
            valid_out_q <= valid_out_d;
            result_q    <= result_d;
            rd_out_q    <= rd_out_d;
            mis_q       <= mis_d;
        end
    end

    assign stall_req  = (state_q == StWait) | (state_q == StDone) | stall;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign valid_out  = valid_out_q;
    assign result     = result_q;
    assign rd_out     = rd_out_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_stage4_mem.sv
// Scoreboard bench for stage4_mem: a byte-addressed memory model predicts every
// request and retirement; a negedge monitor pops and compares them.
module tb_stage4_mem;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        valid = 1'b0;
    logic        do_load = 1'b0;
    logic        do_store = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic        load_unsigned = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] eval = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_req, dmem_we, stall_req, valid_out, misaligned;
    logic [31:0] dmem_addr, dmem_wdata, result;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_out;

    stage4_mem dut (
        .clock(clock), .reset(reset), .stall(stall), .valid(valid),
        .do_load(do_load), .do_store(do_store), .mem_size(mem_size),
        .load_unsigned(load_unsigned), .rd(rd), .eval(eval), .store_data(store_data),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .stall_req(stall_req), .valid_out(valid_out),
        .result(result), .rd_out(rd_out), .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic ld, st, uns;
        logic [1:0] sz;
        logic [4:0] rd;
        logic [31:0] ev, sd;
    } instr_t;
    typedef struct { logic [31:0] result; logic [4:0] rd; logic mis; logic is_mem; } ret_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;

    int n_checks = 0;
    int n_fail = 0;
    instr_t instr_q[$];
    ret_t   ret_q[$];
    req_t   req_q[$];
    logic [7:0]  mem_ref [4096];
    logic [31:0] mem_dut [1024];

    instr_t cur;
    bit     pend = 0, outstanding = 0;
    bit     rst_next = 1, stall_rand = 0, stall_force = 0, spurious_en = 0, ack_force = 0;
    bit     gap_en = 0;
    int     ack_fixed = 0, ack_target = 0, wait_cnt = 0, sr_cnt = 0;
    logic   last_stall = 1'b0, last_rst = 1'b1;

    logic        s_valid_out, s_mis, s_req, s_we;
    logic [31:0] s_result, s_addr, s_wdata;
    logic [4:0]  s_rd;
    logic [3:0]  s_be;
    logic [31:0] lr_addr, lr_wdata, lrt_result;
    logic [3:0]  lr_be;
    logic        lr_we;
    logic [4:0]  lrt_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) mem_ref[a + k] = w[8*k +: 8];
        mem_dut[a / 4] = w;
    endtask

    // Reference model: byte-addressed memory, applied in program order at issue
    task automatic model_accept(input instr_t c);
        ret_t r;
        req_t q;
        int n, a, lane;
        logic [31:0] v;
        r = '{result: 32'h0, rd: 5'd0, mis: 1'b0, is_mem: 1'b0};
        if (!c.ld && !c.st) begin
            r.result = c.ev;
            r.rd = c.rd;
            ret_q.push_back(r);
        end else if (c.sz == 2'd3 || (c.sz == 2'd1 && c.ev[0]) ||
                     (c.sz == 2'd2 && c.ev[1:0] != 2'b00)) begin
            r.mis = 1'b1;
            ret_q.push_back(r);
        end else begin
            n = (c.sz == 2'd0) ? 1 : (c.sz == 2'd1) ? 2 : 4;
            a = int'(c.ev[11:0]);
            lane = int'(c.ev[1:0]);
            q.addr = {c.ev[31:2], 2'b00};
            q.we = c.st;
            q.be = 4'b0000;
            for (int k = 0; k < n; k++) q.be[lane + k] = 1'b1;
            for (int k = 0; k < 4; k++) q.wdata[8*k +: 8] = c.sd[8*(k % n) +: 8];
            req_q.push_back(q);
            r.is_mem = 1'b1;
            if (c.st) begin
                for (int k = 0; k < n; k++) mem_ref[a + k] = c.sd[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = mem_ref[a + k];
                if (!c.uns && n < 4 && v[8*n-1]) begin
                    for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
                end
                r.result = v;
                r.rd = c.rd;
            end
            ret_q.push_back(r);
            outstanding = 1;
        end
    endtask

    // One clock of upstream + memory stimulus, driven at the falling edge
    task automatic step();
        bit exp_sr;
        @(negedge clock);
        s_valid_out = valid_out; s_result = result; s_rd = rd_out; s_mis = misaligned;
        s_req = dmem_req; s_we = dmem_we; s_addr = dmem_addr; s_wdata = dmem_wdata;
        s_be = dmem_be;
        reset = rst_next;
        stall = stall_rand ? ($urandom_range(3) == 0) : stall_force;
        if (dmem_req) begin
            if (wait_cnt == ack_target) begin
                dmem_ack = 1'b1;
                dmem_rdata = mem_dut[dmem_addr[11:2]];
                if (dmem_we && !rst_next) begin
                    for (int k = 0; k < 4; k++)
                        if (dmem_be[k]) mem_dut[dmem_addr[11:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
                end
            end else begin
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
            end
            wait_cnt++;
        end else begin
            dmem_ack = ack_force || (spurious_en && $urandom_range(7) == 0);
            dmem_rdata = $urandom;
            wait_cnt = 0;
            ack_target = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(3));
        end
        if (!pend && instr_q.size() > 0 && !rst_next && !(gap_en && $urandom_range(4) == 0)) begin
            cur = instr_q.pop_front();
            pend = 1;
        end
        valid = pend && !rst_next;
        do_load = cur.ld; do_store = cur.st; mem_size = cur.sz; load_unsigned = cur.uns;
        rd = cur.rd; eval = cur.ev; store_data = cur.sd;
        #1;
        exp_sr = outstanding || stall;
        if (stall_req) sr_cnt++;
        if (!rst_next) check("stall_req", stall_req, exp_sr);
        if (valid && !exp_sr) begin
            model_accept(cur);
            pend = 0;
        end
        if (rst_next) begin
            ret_q.delete();
            req_q.delete();
            outstanding = 0;
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [4:0] r, input logic [31:0] ev, input logic [31:0] sd);
        instr_t c;
        c = '{ld: ld, st: st, uns: uns, sz: sz, rd: r, ev: ev, sd: sd};
        instr_q.push_back(c);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        int left;
        while ((pend || instr_q.size() > 0 || outstanding || ret_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        left = ret_q.size() + req_q.size() + instr_q.size() + int'(pend);
        check("drain_pending", left, 0);
    endtask

    task automatic gen_random(input int count);
        instr_t c;
        int kind;
        for (int i = 0; i < count; i++) begin
            kind = int'($urandom_range(9));
            c.rd = 5'($urandom); c.sd = $urandom; c.uns = 1'($urandom); c.sz = 2'($urandom);
            if (kind < 3) begin
                c.ld = 0; c.st = 0; c.ev = $urandom;
            end else begin
                c.ld = (kind < 7); c.st = !c.ld; c.ev = {20'h0, 12'($urandom)};
                if ($urandom_range(3) != 0) begin
                    if (c.sz == 2'd3) c.sz = 2'd2;
                    if (c.sz == 2'd1) c.ev[0] = 1'b0;
                    if (c.sz == 2'd2) c.ev[1:0] = 2'b00;
                end
            end
            instr_q.push_back(c);
        end
    endtask

    initial forever begin
        @(posedge clock);
        last_stall = stall;
        last_rst = reset;
    end

    // Monitor: retirements, request contents and stability, output hold under stall
    initial begin : monitor
        logic        p_valid, p_mis, p_req, p_we;
        logic [31:0] p_result, p_addr, p_wdata;
        logic [4:0]  p_rd;
        logic [3:0]  p_be;
        ret_t e;
        req_t q;
        p_valid = 0; p_mis = 0; p_req = 0; p_we = 0; p_result = 0; p_addr = 0; p_wdata = 0;
        p_rd = 0; p_be = 0;
        forever begin
            @(negedge clock);
            if (!last_rst) begin
                if (!last_stall) begin
                    if (valid_out) begin
                        if (ret_q.size() == 0) begin
                            check("retire_unexpected", valid_out, 1'b0);
                        end else begin
                            e = ret_q.pop_front();
                            check("ret_result", result, e.result);
                            check("ret_rd", rd_out, e.rd);
                            check("ret_misaligned", misaligned, e.mis);
                            lrt_result = result;
                            lrt_rd = rd_out;
                            if (e.is_mem) outstanding = 0;
                        end
                    end else begin
                        check("idle_misaligned", misaligned, 1'b0);
                    end
                end else begin
                    check("hold_outputs", {valid_out, misaligned, rd_out, result},
                          {p_valid, p_mis, p_rd, p_result});
                end
                if (dmem_req && !p_req) begin
                    if (req_q.size() == 0) begin
                        check("req_unexpected", dmem_req, 1'b0);
                    end else begin
                        q = req_q.pop_front();
                        check("req_addr", dmem_addr, q.addr);
                        check("req_we", dmem_we, q.we);
                        check("req_be", dmem_be, q.be);
                        check("req_wdata", dmem_wdata, q.wdata);
                        lr_addr = dmem_addr; lr_we = dmem_we; lr_be = dmem_be;
                        lr_wdata = dmem_wdata;
                    end
                end else if (dmem_req && p_req) begin
                    check("req_stable", {dmem_we, dmem_be, dmem_addr, dmem_wdata},
                          {p_we, p_be, p_addr, p_wdata});
                end
            end
            p_valid = valid_out; p_mis = misaligned; p_rd = rd_out; p_result = result;
            p_req = dmem_req; p_we = dmem_we; p_addr = dmem_addr; p_wdata = dmem_wdata;
            p_be = dmem_be;
        end
    end

    initial begin
        cur = '{ld: 0, st: 0, uns: 0, sz: 2'd0, rd: 5'd0, ev: 32'h0, sd: 32'h0};
        for (int w = 0; w < 1024; w++) set_word(4 * w, $urandom);

        // Reset values
        rst_next = 1;
        step(); step();
        rst_next = 0;
        step();
        check("rst_outputs", {s_valid_out, s_mis, s_rd, s_result}, 64'h0);
        check("rst_req", {s_req, s_we, s_be}, 64'h0);
        check("rst_addr", s_addr, 32'h0);
        check("rst_wdata", s_wdata, 32'h0);

        // ALU pass-through
        ack_fixed = 0;
        issue(0, 0, 2'd0, 0, 5'd5, 32'h12345678, 32'h0);
        step(); step();
        check("alu_valid", s_valid_out, 1'b1);
        check("alu_result", s_result, 32'h12345678);
        check("alu_rd", s_rd, 5'd5);
        check("alu_no_req", s_req, 1'b0);
        drain(20);

        // Misaligned word load
        issue(1, 0, 2'd2, 0, 5'd7, 32'h6, 32'h0);
        step(); step();
        check("mis_valid", s_valid_out, 1'b1);
        check("mis_flag", s_mis, 1'b1);
        check("mis_rd", s_rd, 5'd0);
        check("mis_no_req", s_req, 1'b0);
        drain(20);

        // Signed byte load, ack in the third WAIT cycle
        set_word(32'h100, 32'h80AABBCC);
        ack_fixed = 2;
        sr_cnt = 0;
        issue(1, 0, 2'd0, 0, 5'd3, 32'h103, 32'h0);
        drain(50);
        check("lb_stall_cycles", sr_cnt, 3);
        check("lb_addr", lr_addr, 32'h100);
        check("lb_be", lr_be, 4'b1000);
        check("lb_result", lrt_result, 32'hFFFFFF80);
        check("lb_rd", lrt_rd, 5'd3);

        // Half store
        ack_fixed = 1;
        issue(0, 1, 2'd1, 0, 5'd12, 32'h202, 32'hDEADBEEF);
        drain(50);
        check("sh_we", lr_we, 1'b1);
        check("sh_be", lr_be, 4'b1100);
        check("sh_wdata", lr_wdata, 32'hBEEFBEEF);
        check("sh_rd", lrt_rd, 5'd0);
        check("sh_result", lrt_result, 32'h0);

        // Zero-wait load: result visible two cycles after acceptance
        set_word(32'h500, 32'hCAFE0123);
        ack_fixed = 0;
        issue(1, 0, 2'd2, 0, 5'd4, 32'h500, 32'h0);
        step(); step(); step();
        check("lat_valid", s_valid_out, 1'b1);
        check("lat_result", s_result, 32'hCAFE0123);
        drain(20);

        // Ack while stalled: park in DONE, ignore acks there, retire once stall drops
        set_word(32'h300, 32'h1234F678);
        ack_fixed = 1;
        issue(1, 0, 2'd1, 0, 5'd9, 32'h300, 32'h0);
        step();
        stall_force = 1;
        step(); step();
        ack_force = 1;
        step();
        check("done_req_clear", s_req, 1'b0);
        check("done_held_valid", s_valid_out, 1'b0);
        step();
        check("done_still_held", s_valid_out, 1'b0);
        ack_force = 0;
        stall_force = 0;
        step(); step();
        check("done_ret_valid", s_valid_out, 1'b1);
        check("done_ret_result", s_result, 32'hFFFFF678);
        check("done_ret_rd", s_rd, 5'd9);
        drain(20);

        // Reset in the second WAIT cycle abandons the load
        ack_fixed = 20;
        issue(1, 0, 2'd2, 0, 5'd11, 32'h400, 32'h0);
        step(); step();
        check("rw_req_live", s_req, 1'b1);
        rst_next = 1;
        step();
        rst_next = 0;
        ack_force = 1;
        step();
        check("rw_req_clear", s_req, 1'b0);
        check("rw_valid_clear", s_valid_out, 1'b0);
        step(); step();
        check("rw_no_retire", s_valid_out, 1'b0);
        ack_force = 0;
        drain(20);

        // Randomised traffic with stalls, variable ack latency and stray acks
        stall_rand = 1;
        spurious_en = 1;
        gap_en = 1;
        ack_fixed = -1;
        gen_random(400);
        drain(20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
